// File: rtl/sipo_word_loader_pkg.sv
// Shared types and defaults for the serial-in/parallel-out word loader.
// State encodings are fixed so bound checkers and waveforms read the same values.
package sipo_word_loader_pkg;

  localparam int SIPO_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_LOAD   = 2'd3
  } sipo_state_e;

  function automatic int sipo_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_word_loader_if.sv
// Bundle of the loader's control, serial input and parallel output signals.
// Handshake: sin_valid is a one-way qualifier with no ready; a bit is taken on any posedge
// clk where sin_valid is high and the loader is capturing, and ignored otherwise.
interface sipo_word_loader_if
  import sipo_word_loader_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
);

  logic             start;
  logic             abort;
  logic             sin;
  logic             sin_valid;
  logic [WIDTH-1:0] q_out;
  logic             ld_out;
  logic             busy;
  logic             parity_err;
  sipo_state_e      state;

  modport master (
    output start, abort, sin, sin_valid,
    input  q_out, ld_out, busy, parity_err, state
  );

  modport slave (
    input  start, abort, sin, sin_valid,
    output q_out, ld_out, busy, parity_err, state
  );

endinterface

// File: rtl/sipo_word_loader_bit_cnt.sv
// Saturating bit counter for the loader: synchronous clear, count enable, and a
// terminal flag raised while the counter holds WIDTH-1 (the last data bit is next).
module sipo_bit_cnt
  import sipo_word_loader_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = sipo_cnt_width(WIDTH);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CW'(WIDTH))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo_word_loader.sv
// Serial-in/parallel-out word loader: frames WIDTH LSB-first bits, then pulses ld_out with q_out.
// Optional even-parity check after the data bits is enabled by defining SIPO_PARITY_CHK_EN.
module sipo_word_loader
  import sipo_word_loader_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sipo_word_loader_if.slave  bus
);

  sipo_state_e      state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] q_reg;
  logic             ld_reg;
  logic             busy_reg;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;
  logic             abort_cap;

  assign abort_cap = bus.abort && ((state == ST_SHIFT) || (state == ST_PARITY));
  assign cnt_clr   = (state == ST_IDLE) || abort_cap;
  assign cnt_en    = (state == ST_SHIFT) && bus.sin_valid;

  sipo_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

`ifdef SIPO_PARITY_CHK_EN
  logic perr_reg;
  localparam sipo_state_e ST_AFTER_DATA = ST_PARITY;
`else
  localparam sipo_state_e ST_AFTER_DATA = ST_LOAD;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      q_reg    <= '0;
      ld_reg   <= 1'b0;
      busy_reg <= 1'b0;
`ifdef SIPO_PARITY_CHK_EN
      perr_reg <= 1'b0;
`endif
    end else begin
      ld_reg   <= 1'b0;
`ifdef SIPO_PARITY_CHK_EN
      perr_reg <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          // abort outranks a simultaneous start
          if (bus.start && !bus.abort) begin
            state    <= ST_SHIFT;
            busy_reg <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bus.abort) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            busy_reg <= 1'b0;
          end else if (bus.sin_valid) begin
            shreg <= {bus.sin, shreg[WIDTH-1:1]};
            if (cnt_tc) state <= ST_AFTER_DATA;
          end
        end
`ifdef SIPO_PARITY_CHK_EN
        ST_PARITY: begin
          if (bus.abort) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            busy_reg <= 1'b0;
          end else if (bus.sin_valid) begin
            if (^{shreg, bus.sin} == 1'b0) begin
              state <= ST_LOAD;
            end else begin
              state    <= ST_IDLE;
              shreg    <= '0;
              busy_reg <= 1'b0;
              perr_reg <= 1'b1;
            end
          end
        end
`endif
        ST_LOAD: begin
          q_reg    <= shreg;
          ld_reg   <= 1'b1;
          state    <= ST_IDLE;
          busy_reg <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q_out  = q_reg;
  assign bus.ld_out = ld_reg;
  assign bus.busy   = busy_reg;
  assign bus.state  = state;
`ifdef SIPO_PARITY_CHK_EN
  assign bus.parity_err = perr_reg;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_word_loader.sv
// Bench for sipo_word_loader (WIDTH=8): directed words, expected loads queued by the driver
// and popped by a negedge monitor whenever ld_out is seen. Parity cases need SIPO_PARITY_CHK_EN.
module tb_sipo_word_loader;
  import sipo_word_loader_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst;

  sipo_word_loader_if #(.WIDTH(W)) bus ();

  sipo_word_loader #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int perr_exp = 0;
  int perr_seen = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_q = '0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (bus.ld_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ld_out", {24'd0, bus.q_out}, 32'hDEAD);
        end else begin
          chk("q_out_on_load", {24'd0, bus.q_out}, {24'd0, exp_q.pop_front()});
        end
      end else if (bus.q_out !== last_q) begin
        chk("q_out_held_without_ld", {24'd0, bus.q_out}, {24'd0, last_q});
      end
      if (bus.parity_err) perr_seen++;
    end
    last_q = bus.q_out;
  end

  // driver tasks (all return on a negedge)
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bus.sin = b;
    bus.sin_valid = 1'b1;
    @(negedge clk);
    bus.sin_valid = 1'b0;
  endtask

  // gap_len idle cycles are inserted after gap_at bits; gap_start raises start in the gap
  task automatic send_word(input logic [W-1:0] w, input int gap_at, input int gap_len,
                           input bit gap_start, input bit bad_par);
    logic par;
    for (int i = 0; i < W; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          bus.start = gap_start;
          @(negedge clk);
        end
        bus.start = 1'b0;
      end
      send_bit(w[i]);
    end
`ifdef SIPO_PARITY_CHK_EN
    par = (^w) ^ bad_par;
    send_bit(par);
`else
    par = bad_par;
    if (par) idle(0);
`endif
  endtask

  task automatic expect_load(input string name);
    @(negedge clk);
    chk(name, {31'd0, bus.ld_out}, 32'd1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.sin = 1'b0;
    bus.sin_valid = 1'b0;
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_q_out", {24'd0, bus.q_out}, 32'd0);
    chk("rst_ld_out", {31'd0, bus.ld_out}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_parity_err", {31'd0, bus.parity_err}, 32'd0);
    chk("rst_state", {30'd0, bus.state}, {30'd0, ST_IDLE});
    rst = 1'b1;
    idle(2);

    // async reset mid-capture after 3 bits
    pulse_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("busy_in_shift", {31'd0, bus.busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_state", {30'd0, bus.state}, {30'd0, ST_IDLE});
    chk("midrst_q_out", {24'd0, bus.q_out}, 32'd0);
    chk("midrst_ld_out", {31'd0, bus.ld_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.sin_valid = 1'b1;
    idle(12);
    bus.sin_valid = 1'b0;
    chk("post_rst_idle", {30'd0, bus.state}, {30'd0, ST_IDLE});

    // basic word 1,0,1,1,0,0,1,0 LSB first
    exp_q.push_back(8'h4D);
    pulse_start();
    send_word(8'h4D, -1, 0, 1'b0, 1'b0);
    chk("pre_load_ld_low", {31'd0, bus.ld_out}, 32'd0);
    expect_load("basic_ld_latency");
    idle(3);

    // same word with a 3-cycle gap between bits 4 and 5
    exp_q.push_back(8'h4D);
    pulse_start();
    send_word(8'h4D, 4, 3, 1'b0, 1'b0);
    expect_load("gap_ld_latency");
    idle(2);

    // abort after 5 bits: no load, q_out stays 4D
    pulse_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_state", {30'd0, bus.state}, {30'd0, ST_IDLE});
    chk("abort_q_out", {24'd0, bus.q_out}, 32'h4D);
    idle(4);

    // start and abort together in IDLE: stay idle
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_idle", {30'd0, bus.state}, {30'd0, ST_IDLE});
    idle(2);

    // back-to-back: A5, then start during its ld_out cycle, then FF
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hFF);
    pulse_start();
    send_word(8'hA5, -1, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_first_ld", {31'd0, bus.ld_out}, 32'd1);
    pulse_start();
    chk("b2b_restart_busy", {31'd0, bus.busy}, 32'd1);
    send_word(8'hFF, -1, 0, 1'b0, 1'b0);
    expect_load("b2b_second_ld");
    idle(2);

    // start while busy is ignored; abort during LOAD is ignored
    exp_q.push_back(8'h3C);
    pulse_start();
    send_word(8'h3C, 3, 2, 1'b1, 1'b0);
    chk("load_state", {30'd0, bus.state}, {30'd0, ST_LOAD});
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_in_load_ld", {31'd0, bus.ld_out}, 32'd1);
    idle(3);

`ifdef SIPO_PARITY_CHK_EN
    // wrong parity bit: error pulse, no load, q_out unchanged
    pulse_start();
    send_word(8'h4D, -1, 0, 1'b0, 1'b1);
    perr_exp++;
    chk("parity_err_pulse", {31'd0, bus.parity_err}, 32'd1);
    chk("parity_err_no_ld", {31'd0, bus.ld_out}, 32'd0);
    @(negedge clk);
    chk("parity_err_one_cycle", {31'd0, bus.parity_err}, 32'd0);
    chk("parity_err_q_held", {24'd0, bus.q_out}, 32'h3C);
    idle(2);
    exp_q.push_back(8'h4D);
    pulse_start();
    send_word(8'h4D, -1, 0, 1'b0, 1'b0);
    expect_load("parity_ok_ld");
    idle(2);
`endif

    idle(5);
    chk("all_loads_seen", exp_q.size(), 32'd0);
    chk("parity_err_count", perr_seen, perr_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish by %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
